tt_um_priority_decoder: RTL

Sequential 4-to-16 one-hot decoder; the receive end for the 16-input priority encoder's code byte. Takes the encoder's 8-bit output code (index 0x00–0x0F, or 0xF0 for "no input active"), validates it, and builds a 16-bit one-hot mask. The mask can either replace the previous value or be OR-accumulated into it. The mask leaves the chip as two 8-bit beats on `uo_out`, with status flags on the upper bidirectional pins. Sits in the same tile wrapper as the encoder.

---
 rtl/tt_um_priority_decoder.sv | 100 ++++++++++
 1 files changed

// File: rtl/tt_um_priority_decoder.sv
// Receive end of the 16-input priority encoder: validates the code byte and
// builds a 16-bit one-hot mask, presented as two byte beats on uo_out.
module tt_um_priority_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DECODE  = 2'd1,
    SHOW_LO = 2'd2,
    SHOW_HI = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] mask_q, mask_d;
  logic [7:0]  code_r_q, code_r_d;
  logic        err_q, err_d;
  logic        load_q, load_d;

  logic load, accum, clear, load_edge;
  logic busy, half;
  logic [15:0] onehot;

  // ena and uio_in[7:3] have no function in this tile.
  logic unused;
  assign unused = ena ^ (^uio_in[7:3]);

  assign load      = uio_in[0];
  assign accum     = uio_in[1];
  assign clear     = uio_in[2];
  assign load_edge = load & ~load_q;
  assign onehot    = 16'd1 << code_r_q[3:0];

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    code_r_d = code_r_q;
    err_d    = err_q;
    load_d   = load;
    if (clear) begin
      // Clear wins over a coincident load edge and over the DECODE update.
      state_d = IDLE;
      mask_d  = 16'h0000;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_edge) begin
            code_r_d = ui_in;
            state_d  = DECODE;
          end
        end
        DECODE: begin
          if (code_r_q[7:4] == 4'h0) begin
            mask_d = accum ? (mask_q | onehot) : onehot;
          end else if (code_r_q == 8'hF0) begin
            mask_d = accum ? mask_q : 16'h0000;
          end else begin
            err_d = 1'b1;
          end
          state_d = SHOW_LO;
        end
        SHOW_LO: state_d = SHOW_HI;
        SHOW_HI: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mask_q   <= 16'h0000;
      code_r_q <= 8'h00;
      err_q    <= 1'b0;
      load_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      code_r_q <= code_r_d;
      err_q    <= err_d;
      load_q   <= load_d;
    end
  end

  // Outputs come only from registers; half selects which mask byte is shown.
  assign busy    = (state_q != IDLE);
  assign half    = (state_q == SHOW_HI);
  assign uo_out  = half ? mask_q[15:8] : mask_q[7:0];
  assign uio_out = {|mask_q, err_q, half, busy, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule
